// File: rtl/pwm_duty_scheduler.sv
// Duty-cycle sequencer for the 8-bit PWM: sample FIFO, soft-start/stop ramps,
// and one duty update per PWM period, applied on the counter wrap.
module pwm_duty_scheduler #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PERIOD_BITS = 8,
   parameter int unsigned RAMP_STEP   = 1,
   parameter int unsigned MID_DUTY    = 128
) (
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic       ipEnable,
   input  logic [7:0] ipSample,
   input  logic       ipSampleValid,
   output logic       opSampleReady,
   output logic [7:0] opDutyCycle,
   output logic       opPeriodStart,
   output logic       opUnderrun,
   output logic [1:0] opState
);

   localparam int unsigned DUTY_W = 8;
   localparam int unsigned SUM_W  = DUTY_W + 1;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = AW + 1;

   localparam logic [PERIOD_BITS-1:0] CNT_MAX  = '1;
   localparam logic [DUTY_W-1:0]      STEP_D   = DUTY_W'(RAMP_STEP);
   localparam logic [DUTY_W-1:0]      MID_D    = DUTY_W'(MID_DUTY);
   localparam logic [SUM_W-1:0]       MID_S    = SUM_W'(MID_DUTY);
   localparam logic [CW-1:0]          FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_RAMP_UP   = 2'b01;
   localparam logic [1:0] ST_RUN       = 2'b10;
   localparam logic [1:0] ST_RAMP_DOWN = 2'b11;

   logic [PERIOD_BITS-1:0] r_cnt;
   logic [1:0]             r_state;
   logic [DUTY_W-1:0]      r_duty;
   logic                   r_pstart;
   logic                   r_underrun;
   logic                   r_ready;
   logic [DUTY_W-1:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;

   logic [PERIOD_BITS-1:0] w_cnt_nxt;
   logic                   w_boundary;
   logic [1:0]             w_state_nxt;
   logic [DUTY_W-1:0]      w_duty_nxt;
   logic [SUM_W-1:0]       w_sum;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_flush;
   logic                   w_underrun_nxt;
   logic [CW-1:0]          w_count_nxt;
   logic                   w_ready_nxt;

   assign w_cnt_nxt  = r_cnt + PERIOD_BITS'(1);
   assign w_boundary = (r_cnt == CNT_MAX);
   assign w_sum      = SUM_W'(r_duty) + SUM_W'(STEP_D);

   // Next state and duty; everything holds except on the period boundary
   always_comb begin
      w_state_nxt    = r_state;
      w_duty_nxt     = r_duty;
      w_pop          = 1'b0;
      w_flush        = 1'b0;
      w_underrun_nxt = 1'b0;
      if (w_boundary) begin
         case (r_state)
            ST_IDLE: begin
               w_duty_nxt = '0;
               if (ipEnable) w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
               if (!ipEnable) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (w_sum >= MID_S) begin
                  w_duty_nxt  = MID_D;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_duty_nxt = w_sum[DUTY_W-1:0];
               end
            end
            ST_RUN: begin
               if (!ipEnable) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (r_count != '0) begin
                  w_pop      = 1'b1;
                  w_duty_nxt = r_mem[r_rd_ptr];
               end else begin
                  w_underrun_nxt = 1'b1;
               end
            end
            default: begin
               if (r_duty <= STEP_D) begin
                  w_duty_nxt  = '0;
                  w_state_nxt = ST_IDLE;
                  w_flush     = 1'b1;
               end else begin
                  w_duty_nxt = r_duty - STEP_D;
               end
            end
         endcase
      end
   end

   // FIFO occupancy and the registered ready that follows it
   always_comb begin
      w_push      = ipSampleValid && r_ready;
      w_count_nxt = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
      w_ready_nxt = (w_count_nxt != FULL_CNT) &&
                    ((w_state_nxt == ST_RAMP_UP) || (w_state_nxt == ST_RUN));
   end

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         r_cnt      <= '0;
         r_state    <= ST_IDLE;
         r_duty     <= '0;
         r_pstart   <= 1'b0;
         r_underrun <= 1'b0;
         r_ready    <= 1'b0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_pstart   <= (w_cnt_nxt == CNT_MAX);
         r_state    <= w_state_nxt;
         r_duty     <= w_duty_nxt;
         r_underrun <= w_underrun_nxt;
         r_ready    <= w_ready_nxt;
         r_count    <= w_count_nxt;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge ipClk) begin
      if (w_push) r_mem[r_wr_ptr] <= ipSample;
   end

   assign opSampleReady = r_ready;
   assign opDutyCycle   = r_duty;
   assign opPeriodStart = r_pstart;
   assign opUnderrun    = r_underrun;
   assign opState       = r_state;

endmodule
